// File: rtl/sseg_scan_capture.sv
// rtl/sseg_scan_capture.sv - seven-segment scan bus monitor
// Rebuilds hex value, sign and validity from a multiplexed active-low display bus.
module sseg_scan_capture #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segs,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    neg,
  output logic                    valid,
  output logic                    frame_done,
  output logic                    err
);

  localparam int         MSD        = NUM_DIGITS - 1;
  localparam logic [7:0] STABLE_TGT = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  logic [6:0]              r_s_segs;
  logic [NUM_DIGITS-1:0]   r_s_en;
  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic [6:0]              r_ref_segs;
  logic [NUM_DIGITS-1:0]   r_ref_en;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [NUM_DIGITS-1:0]   r_bad;
  logic [4*NUM_DIGITS-1:0] r_buf;
  logic                    r_sign;

  logic                    w_onehot;
  logic                    w_match;
  logic                    w_restart;
  logic                    w_active;
  logic [7:0]              w_cnt_inc;
  logic [7:0]              w_cnt_next;
  logic                    w_capture;
  logic                    w_complete;
  logic                    w_is_msd;
  logic                    w_illegal;
  logic [3:0]              w_nib;
  logic                    w_hex;
  logic                    w_minus;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_mask_next;
  logic [NUM_DIGITS-1:0]   w_bad_next;
  logic [4*NUM_DIGITS-1:0] w_buf_next;
  logic                    w_sign_next;

  assign w_onehot   = ($countones(r_s_en) == 1);
  assign w_match    = (r_s_segs == r_ref_segs) && (r_s_en == r_ref_en);
  // Idle, or any change while settling/holding, restarts tracking on this sample.
  assign w_restart  = (r_state == S_IDLE) || !w_match;
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_cnt_next = w_restart ? 8'd1 : w_cnt_inc;
  assign w_active   = w_restart ? w_onehot : (r_state != S_HOLD);
  assign w_capture  = w_active && (w_cnt_next >= STABLE_TGT);
  assign w_complete = &r_mask;
  assign w_is_msd   = r_s_en[MSD];
  assign w_illegal  = !(w_hex || w_blank || (w_minus && w_is_msd));

  always_comb begin
    w_nib   = 4'h0;
    w_hex   = 1'b1;
    w_minus = 1'b0;
    w_blank = 1'b0;
    case (r_s_segs)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h3F: begin
        w_hex   = 1'b0;
        w_minus = 1'b1;
      end
      7'h7F: begin
        w_hex   = 1'b0;
        w_blank = 1'b1;
      end
      default: w_hex = 1'b0;
    endcase
  end

  // Completion clears the frame first so a same-cycle capture lands in the new frame.
  always_comb begin
    w_mask_next = w_complete ? '0 : r_mask;
    w_bad_next  = w_complete ? '0 : r_bad;
    w_sign_next = w_complete ? 1'b0 : r_sign;
    w_buf_next  = r_buf;
    if (w_capture) begin
      w_mask_next = w_mask_next | r_s_en;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_s_en[i]) begin
          w_bad_next[i]       = w_illegal;
          w_buf_next[4*i +: 4] = w_illegal ? 4'h0 : w_nib;
        end
      end
      if (w_is_msd) begin
        w_sign_next = w_minus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_segs   <= 7'h7F;
      r_s_en     <= '0;
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_ref_segs <= 7'h7F;
      r_ref_en   <= '0;
      r_mask     <= '0;
      r_bad      <= '0;
      r_buf      <= '0;
      r_sign     <= 1'b0;
      value      <= '0;
      neg        <= 1'b0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_s_segs <= segs;
      r_s_en   <= dig_en;

      if (w_restart && !w_onehot) begin
        r_state <= S_IDLE;
      end else if (w_active) begin
        r_cnt      <= w_cnt_next;
        r_ref_segs <= r_s_segs;
        r_ref_en   <= r_s_en;
        r_state    <= w_capture ? S_HOLD : S_SETTLE;
      end

      r_mask <= w_mask_next;
      r_bad  <= w_bad_next;
      r_buf  <= w_buf_next;
      r_sign <= w_sign_next;

      frame_done <= w_complete;
      err        <= w_capture && w_illegal;
      if (w_complete) begin
        value <= r_buf;
        neg   <= r_sign;
        valid <= ~|r_bad;
      end
    end
  end

endmodule
